// File: rtl/sfx_audio_scheduler.sv
// sfx_audio_scheduler
//   Shares one sound-effect sample ROM among four prioritised requesters and
//   streams one 16-bit sample per sample tick to the codec's left and right
//   Avalon-ST sinks. Idle ticks produce silence (0x0000) with identical timing.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   req[3:0]              play request per channel (bit 3 highest priority)
//   stop_all              abort playback
//   rom_rd, rom_addr      ROM read strobe/address (one cycle per fetch)
//   rom_data              ROM data, valid the cycle after rom_rd
//   L_/R_READY            sink ready
//   L_/R_DATA, L_/R_VALID sample stream to the codec
//   busy, active_ch       playback status (active_ch is 0 when idle)
//   done[3:0]             pulse when channel i played its last sample
//   overrun               pulse when an unaccepted sample was overwritten
module sfx_audio_scheduler #(
  parameter int SAMPLE_PERIOD = 285,
  parameter int ADDR_W        = 16,
  parameter int BASE0         = 0,
  parameter int BASE1         = 17555,
  parameter int BASE2         = 34088,
  parameter int BASE3         = 34088,
  parameter int LEN0          = 17555,
  parameter int LEN1          = 16533,
  parameter int LEN2          = 0,
  parameter int LEN3          = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic                stop_all,
  output logic                rom_rd,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic signed [15:0]  rom_data,
  input  logic                L_READY,
  input  logic                R_READY,
  output logic signed [15:0]  L_DATA,
  output logic signed [15:0]  R_DATA,
  output logic                L_VALID,
  output logic                R_VALID,
  output logic                busy,
  output logic [1:0]          active_ch,
  output logic [3:0]          done,
  output logic                overrun
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0] EN = {LEN3 != 0, LEN2 != 0, LEN1 != 0, LEN0 != 0};
  localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

  localparam bit PARAMS_OK =
    (SAMPLE_PERIOD >= 4) &&
    ((LEN0 == 0) || (longint'(BASE0) + LEN0 - 1 < ADDR_SPAN)) &&
    ((LEN1 == 0) || (longint'(BASE1) + LEN1 - 1 < ADDR_SPAN)) &&
    ((LEN2 == 0) || (longint'(BASE2) + LEN2 - 1 < ADDR_SPAN)) &&
    ((LEN3 == 0) || (longint'(BASE3) + LEN3 - 1 < ADDR_SPAN));

  if (!PARAMS_OK) begin : g_param_check
    $error("sfx_audio_scheduler: SAMPLE_PERIOD < 4 or a channel region exceeds ADDR_W");
  end

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] c);
    case (c)
      2'd0:    base_of = ADDR_W'(BASE0);
      2'd1:    base_of = ADDR_W'(BASE1);
      2'd2:    base_of = ADDR_W'(BASE2);
      default: base_of = ADDR_W'(BASE3);
    endcase
  endfunction

  // Index of the final sample of a channel (LEN-1).
  function automatic logic [ADDR_W-1:0] last_of(input logic [1:0] c);
    case (c)
      2'd0:    last_of = ADDR_W'(LEN0 - 1);
      2'd1:    last_of = ADDR_W'(LEN1 - 1);
      2'd2:    last_of = ADDR_W'(LEN2 - 1);
      default: last_of = ADDR_W'(LEN3 - 1);
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, PLAY, FETCH, CAPTURE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [1:0]          ch, ch_n;
  logic [ADDR_W-1:0]   idx, idx_n;
  logic [3:0]          done_n;
  logic [3:0]          reqm;
  logic [1:0]          win;
  logic                win_vld;
  logic                take;
  logic                vld_p0, vld_p1, fetch_p1;
  logic signed [DATA_W-1:0] smp_p1;

  assign tick = (cnt == CNT_LAST);
  assign reqm = req & EN;

  // Highest enabled requester wins.
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (reqm[i]) begin
        win_vld = 1'b1;
        win     = 2'(i);
      end
    end
  end

  // A start/stop during FETCH or CAPTURE leaves the in-flight sample to the
  // datapath pipeline; only the playback bookkeeping is overridden.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    idx_n   = idx;
    done_n  = '0;
    take    = win_vld && ((state == IDLE) || (win >= ch));
    if (stop_all) begin
      state_n = IDLE;
    end else if (take) begin
      ch_n    = win;
      idx_n   = '0;
      state_n = (state == PLAY && tick) ? FETCH : PLAY;
    end else begin
      case (state)
        IDLE:    state_n = IDLE;
        PLAY:    if (tick) state_n = FETCH;
        FETCH:   state_n = CAPTURE;
        CAPTURE: begin
          if (idx == last_of(ch)) begin
            state_n    = IDLE;
            done_n[ch] = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = PLAY;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      state <= IDLE;
      ch    <= '0;
      idx   <= '0;
      done  <= '0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      state <= state_n;
      ch    <= ch_n;
      idx   <= idx_n;
      done  <= done_n;
    end
  end

  assign busy      = (state != IDLE);
  assign active_ch = busy ? ch : 2'd0;
  assign rom_rd    = (state == FETCH);
  assign rom_addr  = rom_rd ? (base_of(ch) + idx) : '0;

  // Stage p0: fetch cycle (tick + 1)
  // Stage p1: ROM data cycle (tick + 2); sample loads into the sinks at its end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      fetch_p1 <= 1'b0;
    end else begin
      vld_p0   <= tick;
      vld_p1   <= vld_p0;
      fetch_p1 <= rom_rd;
    end
  end

  assign smp_p1 = fetch_p1 ? rom_data : '0;

  // Sink stage: VALID drops after a transfer unless a new sample reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      L_DATA  <= '0;
      R_DATA  <= '0;
      L_VALID <= 1'b0;
      R_VALID <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= vld_p1 && ((L_VALID && !L_READY) || (R_VALID && !R_READY));
      if (vld_p1) begin
        L_DATA  <= smp_p1;
        L_VALID <= 1'b1;
      end else if (L_READY) begin
        L_VALID <= 1'b0;
      end
      if (vld_p1) begin
        R_DATA  <= smp_p1;
        R_VALID <= 1'b1;
      end else if (R_READY) begin
        R_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfx_audio_scheduler.sv
module tb_sfx_audio_scheduler;

  localparam int SP = 8;
  localparam int AW = 8;
  localparam int BASE_T [4] = '{0, 16, 32, 40};
  localparam int LEN_T  [4] = '{4, 3, 2, 0};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req = '0;
  logic          stop_all = 1'b0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0;
  logic          L_READY = 1'b1;
  logic          R_READY = 1'b1;
  logic [15:0]   L_DATA, R_DATA;
  logic          L_VALID, R_VALID;
  logic          busy;
  logic [1:0]    active_ch;
  logic [3:0]    done;
  logic          overrun;

  sfx_audio_scheduler #(
    .SAMPLE_PERIOD(SP), .ADDR_W(AW),
    .BASE0(0), .BASE1(16), .BASE2(32), .BASE3(40),
    .LEN0(4), .LEN1(3), .LEN2(2), .LEN3(0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .stop_all(stop_all),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .L_READY(L_READY), .R_READY(R_READY),
    .L_DATA(L_DATA), .R_DATA(R_DATA), .L_VALID(L_VALID), .R_VALID(R_VALID),
    .busy(busy), .active_ch(active_ch), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM: word = 0x1000 + address, one cycle after the strobe; junk otherwise.
  always @(posedge clk) rom_data <= rom_rd ? (16'h1000 + {8'h00, rom_addr}) : 16'hBEEF;

  int errors = 0;
  int checks = 0;
  int cur_k  = 0;

  // Reference model state for the current cycle.
  bit   m_busy;
  int   m_ch, m_pos;
  bit   m_rd;
  int   m_addr;
  logic [3:0] m_done;
  bit   m_lv, m_rv, m_ovr;
  int   m_ld, m_rdat;
  int   commit_at, c_ch, c_pos;
  int   deliver [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cur_k, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ch = 0; m_pos = 0; m_rd = 0; m_addr = 0; m_done = '0;
    m_lv = 0; m_rv = 0; m_ovr = 0; m_ld = 0; m_rdat = 0;
    commit_at = -1; c_ch = 0; c_pos = 0;
    deliver.delete();
  endtask

  task automatic compare_model();
    chk("rom_rd",    {31'd0, rom_rd},    {31'd0, m_rd});
    chk("rom_addr",  {24'd0, rom_addr},  m_rd ? m_addr : 0);
    chk("busy",      {31'd0, busy},      {31'd0, m_busy});
    chk("active_ch", {30'd0, active_ch}, m_busy ? m_ch : 0);
    chk("done",      {28'd0, done},      {28'd0, m_done});
    chk("L_VALID",   {31'd0, L_VALID},   {31'd0, m_lv});
    chk("R_VALID",   {31'd0, R_VALID},   {31'd0, m_rv});
    chk("L_DATA",    {16'd0, L_DATA},    m_ld);
    chk("R_DATA",    {16'd0, R_DATA},    m_rdat);
    chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
  endtask

  // Advance the model by one cycle given the inputs presented during cycle k.
  task automatic model_step(input int k);
    bit tick, take, fetch_here, load;
    int w, v;
    bit n_busy, n_lv, n_rv;
    int n_ch, n_pos, n_addr;
    logic [3:0] n_done;
    tick = (k % SP) == SP - 1;
    w = -1;
    for (int i = 0; i < 4; i++) if (req[i] && LEN_T[i] != 0) w = i;
    take = (w >= 0) && (!m_busy || w >= m_ch);
    n_busy = m_busy; n_ch = m_ch; n_pos = m_pos; n_addr = 0; n_done = '0;
    fetch_here = tick && m_busy && !stop_all;
    if (stop_all) begin
      n_busy = 0; commit_at = -1;
    end else if (take) begin
      n_busy = 1; n_ch = w; n_pos = 0; commit_at = -1;
    end else if (commit_at == k) begin
      commit_at = -1;
      if (c_pos == LEN_T[c_ch] - 1) begin n_busy = 0; n_done[c_ch] = 1'b1; end
      else n_pos = c_pos + 1;
    end
    if (fetch_here) begin
      n_addr = BASE_T[n_ch] + n_pos;
      commit_at = k + 2; c_ch = n_ch; c_pos = n_pos;
    end
    if (tick) deliver[k + 3] = fetch_here ? (32'h1000 + n_addr) : 0;
    load = deliver.exists(k + 1);
    if (load) begin
      v = deliver[k + 1];
      deliver.delete(k + 1);
      m_ovr = (m_lv && !L_READY) || (m_rv && !R_READY);
      n_lv = 1; n_rv = 1; m_ld = v; m_rdat = v;
    end else begin
      m_ovr = 0;
      n_lv = m_lv && !L_READY;
      n_rv = m_rv && !R_READY;
    end
    m_lv = n_lv; m_rv = n_rv;
    m_busy = n_busy; m_ch = n_ch; m_pos = n_pos;
    m_rd = fetch_here; m_addr = n_addr; m_done = n_done;
  endtask

  // Hand-computed expectations for the directed scenarios.
  task automatic literal_checks(input int scen, input int k);
    case (scen)
      0: begin
        if (k == 8)  begin chk("s0_rd", {31'd0, rom_rd}, 1); chk("s0_addr0", {24'd0, rom_addr}, 0); end
        if (k == 10) begin chk("s0_L0", {16'd0, L_DATA}, 32'h1000); chk("s0_Lv", {31'd0, L_VALID}, 1); end
        if (k == 11) chk("s0_Lv_drop", {31'd0, L_VALID}, 0);
        if (k == 18) chk("s0_R1", {16'd0, R_DATA}, 32'h1001);
        if (k == 34) begin
          chk("s0_done", {28'd0, done}, 1);
          chk("s0_busy", {31'd0, busy}, 0);
          chk("s0_L3", {16'd0, L_DATA}, 32'h1003);
        end
        if (k == 42) begin chk("s0_sil", {16'd0, L_DATA}, 0); chk("s0_silv", {31'd0, L_VALID}, 1); end
      end
      1: begin
        if (k == 16) chk("s1_addr1", {24'd0, rom_addr}, 1);
        if (k == 21) chk("s1_act1", {30'd0, active_ch}, 1);
        if (k == 24) chk("s1_addr16", {24'd0, rom_addr}, 16);
        if (k == 42) chk("s1_done1", {28'd0, done}, 4'b0010);
        if (k == 43) chk("s1_act0", {30'd0, active_ch}, 0);
      end
      2: begin
        if (k == 16) chk("s2_addr17", {24'd0, rom_addr}, 17);
        if (k == 26) chk("s2_done1", {28'd0, done}, 4'b0010);
      end
      3: begin
        if (k == 24) chk("s3_restart", {24'd0, rom_addr}, 0);
        if (k == 48) chk("s3_addr3", {24'd0, rom_addr}, 3);
        if (k == 50) chk("s3_done0", {28'd0, done}, 1);
      end
      4: begin
        if (k == 17) begin chk("s4_Lhold", {16'd0, L_DATA}, 32'h1000); chk("s4_Lv17", {31'd0, L_VALID}, 1); end
        if (k == 18) begin
          chk("s4_ovr", {31'd0, overrun}, 1);
          chk("s4_Lnew", {16'd0, L_DATA}, 32'h1001);
          chk("s4_Rv", {31'd0, R_VALID}, 1);
        end
        if (k == 19) chk("s4_ovr_once", {31'd0, overrun}, 0);
      end
      5: begin
        if (k == 17) chk("s5_busy0", {31'd0, busy}, 0);
        if (k == 18) chk("s5_inflight", {16'd0, L_DATA}, 32'h1001);
        if (k == 26) begin chk("s5_sil", {16'd0, L_DATA}, 0); chk("s5_silv", {31'd0, L_VALID}, 1); end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input int scen, input int k);
    req = '0; stop_all = 1'b0; L_READY = 1'b1; R_READY = 1'b1;
    case (scen)
      0: if (k == 0) req = 4'b0001;
      1: begin if (k == 0) req = 4'b0001; if (k == 19) req = 4'b0010; end
      2: begin if (k == 0) req = 4'b0010; if (k == 12) req = 4'b0001; end
      3: if (k == 0 || k == 20) req = 4'b0001;
      4: begin if (k == 0) req = 4'b0001; L_READY = (k > 20); end
      5: begin if (k == 0) req = 4'b0001; stop_all = (k == 16); end
      default: begin
        for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 31) == 0);
        stop_all = ($urandom_range(0, 199) == 0);
        L_READY  = ($urandom_range(0, 3) != 0);
        R_READY  = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  // Assert reset (possibly mid-playback), check outputs clear at once, release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; stop_all = 1'b0; L_READY = 1'b1; R_READY = 1'b1;
    #1;
    chk("rst_rom_rd", {31'd0, rom_rd}, 0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 0);
    chk("rst_valid", {30'd0, L_VALID, R_VALID}, 0);
    chk("rst_data", {L_DATA, R_DATA}, 0);
    chk("rst_status", {25'd0, busy, active_ch, done}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run(input int scen, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      cur_k = k;
      compare_model();
      literal_checks(scen, k);
      drive(scen, k);
      model_step(k);
    end
  endtask

  initial begin
    model_reset();
    do_reset(); run(0, 50);
    do_reset(); run(1, 50);
    do_reset(); run(2, 30);
    do_reset(); run(3, 55);
    do_reset(); run(4, 30);
    do_reset(); run(5, 30);
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      run(9, 1200 + seg * 37);
    end
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
